// File: rtl/alu_dispatcher_if.sv
// Instruction, arithmetic-unit and result bus of the ALU dispatcher.
interface alu_dispatcher_if;
    logic        INS_VALID;
    logic        INS_READY;
    logic [1:0]  INS_OP;
    logic [1:0]  INS_MOVI;
    logic [31:0] INS_A;
    logic [31:0] INS_B;
    logic [3:0]  INS_TAG;

    logic        AU_ACT;
    logic [1:0]  AU_OP_CODE;
    logic [1:0]  AU_MOVI;
    logic [31:0] AU_REG_A;
    logic [31:0] AU_REG_B;
    logic [31:0] AU_MEM;
    logic [31:0] AU_IMM;
    logic [31:0] AU_DATA;
    logic        AU_DATA_VALID;

    logic        RES_VALID;
    logic        RES_READY;
    logic [31:0] RES_DATA;
    logic [3:0]  RES_TAG;
    logic        RES_ERR;

    // Caller side: issues instructions, plays the arithmetic unit, consumes results.
    modport master (
        output INS_VALID, INS_OP, INS_MOVI, INS_A, INS_B, INS_TAG,
        input  INS_READY,
        input  AU_ACT, AU_OP_CODE, AU_MOVI, AU_REG_A, AU_REG_B, AU_MEM, AU_IMM,
        output AU_DATA, AU_DATA_VALID,
        input  RES_VALID, RES_DATA, RES_TAG, RES_ERR,
        output RES_READY
    );

    // Dispatcher side.
    modport slave (
        input  INS_VALID, INS_OP, INS_MOVI, INS_A, INS_B, INS_TAG,
        output INS_READY,
        output AU_ACT, AU_OP_CODE, AU_MOVI, AU_REG_A, AU_REG_B, AU_MEM, AU_IMM,
        input  AU_DATA, AU_DATA_VALID,
        output RES_VALID, RES_DATA, RES_TAG, RES_ERR,
        input  RES_READY
    );
endinterface

// File: rtl/alu_dispatcher.sv
// Instruction queue plus single-issue dispatcher for an external arithmetic unit.
// Define ALU_DISPATCH_TIMEOUT_EN to abort a WAIT that outlasts TIMEOUT cycles.

// Generic circular FIFO with occupancy counter.
// Latency: a pushed entry is visible on rd_dat the cycle after the push edge.
// Backpressure: wr_rdy low when full (from occupancy only); rd_vld low when empty.
module alu_dispatcher_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             push;
    logic             pop;

    assign wr_rdy = (count != (PW+1)'(DEPTH));
    assign rd_vld = (count != '0);
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_vld && rd_rdy;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Queues instructions and runs them one at a time through the arithmetic unit.
// Latency: ISSUE one cycle after pop, result the cycle after AU_DATA_VALID.
// Backpressure: INS_READY drops when the queue is full; OUT holds until RES_READY.
module alu_dispatcher #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input logic             CLK,
    input logic             RST_N,
    alu_dispatcher_if.slave bus
);
    typedef struct packed {
        logic [1:0]  op;
        logic [1:0]  movi;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
    } ins_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUT
    } state_t;

    state_t state;
    state_t state_nxt;
    ins_t   ins_in;
    ins_t   fifo_dat;
    ins_t   cur_q;
    logic   fifo_vld;
    logic   fifo_rdy;
    logic   pop;
    logic   au_done;
    logic   wait_exit;
    logic [31:0] res_data_q;
    logic [3:0]  res_tag_q;

    assign ins_in = {bus.INS_OP, bus.INS_MOVI, bus.INS_A, bus.INS_B, bus.INS_TAG};

    alu_dispatcher_fifo #(
        .WIDTH ($bits(ins_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .wr_vld (bus.INS_VALID),
        .wr_rdy (fifo_rdy),
        .wr_dat (ins_in),
        .rd_vld (fifo_vld),
        .rd_rdy (pop),
        .rd_dat (fifo_dat)
    );

    assign bus.INS_READY = fifo_rdy;
    assign pop           = (state == S_IDLE) && fifo_vld;
    // A late or spurious AU_DATA_VALID outside WAIT has no effect.
    assign au_done       = (state == S_WAIT) && bus.AU_DATA_VALID;

`ifdef ALU_DISPATCH_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] tmo_cnt;
    logic          tmo_done;
    logic          res_err_q;

    // The counter holds the number of WAIT cycles already spent without a result.
    assign tmo_done  = (state == S_WAIT) && !bus.AU_DATA_VALID &&
                       (tmo_cnt == TW'(TIMEOUT - 1));
    assign wait_exit = au_done || tmo_done;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tmo_cnt <= '0;
        end else if ((state == S_WAIT) && !wait_exit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            res_err_q <= 1'b0;
        end else if (au_done) begin
            res_err_q <= 1'b0;
        end else if (tmo_done) begin
            res_err_q <= 1'b1;
        end
    end

    assign bus.RES_ERR = res_err_q;
`else
    assign wait_exit   = au_done;
    assign bus.RES_ERR = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (fifo_vld) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (wait_exit) state_nxt = S_OUT;
            S_OUT:   if (bus.RES_READY) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operands are captured only on pop, so they stay frozen through ISSUE and WAIT.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cur_q <= '0;
        end else if (pop) begin
            cur_q <= fifo_dat;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            res_data_q <= '0;
            res_tag_q  <= '0;
        end else if (au_done) begin
            res_data_q <= bus.AU_DATA;
            res_tag_q  <= cur_q.tag;
        end else if (wait_exit) begin
            res_data_q <= '0;
            res_tag_q  <= cur_q.tag;
        end
    end

    assign bus.AU_ACT     = (state == S_ISSUE);
    assign bus.AU_OP_CODE = cur_q.op;
    assign bus.AU_MOVI    = cur_q.movi;
    assign bus.AU_REG_A   = cur_q.a;

    always_comb begin
        bus.AU_REG_B = '0;
        bus.AU_MEM   = '0;
        bus.AU_IMM   = '0;
        case (cur_q.movi)
            2'd0:    bus.AU_REG_B = cur_q.b;
            2'd1:    bus.AU_MEM   = cur_q.b;
            2'd2:    bus.AU_IMM   = cur_q.b;
            default: ;
        endcase
    end

    assign bus.RES_VALID = (state == S_OUT);
    assign bus.RES_DATA  = res_data_q;
    assign bus.RES_TAG   = res_tag_q;
endmodule

// File: doc/alu_dispatcher.md
ALU_DISPATCHER -- requirements
Module: alu_dispatcher

Interface
REQ-001 SHALL have parameters: FIFO_DEPTH, default 4, instruction queue entries (power of two, >=2); TIMEOUT, default 15, max WAIT cycles before abort.
REQ-002 SHALL have ports, clock and reset first:
CLK  in  1  clock; all state updates on rising edge.
RST_N  in  1  reset, asynchronous, active-low.
INS_VALID  in  1  instruction offered.
INS_READY  out  1  queue can accept.
INS_OP  in  2  operator: 0 add, 1 sub, 2 mul, 3 div.
INS_MOVI  in  2  operand-B route: 0 REG_B, 1 MEM, 2 IMM, 3 none.
INS_A  in  32  first operand.
INS_B  in  32  second operand.
INS_TAG  in  4  caller tag, returned with result.
AU_ACT  out  1  start pulse to arithmetic unit.
AU_OP_CODE  out  2  operator to arithmetic unit.
AU_MOVI  out  2  operand route to arithmetic unit.
AU_REG_A  out  32  first operand.
AU_REG_B / AU_MEM / AU_IMM  out  32 each  routed second operand.
AU_DATA  in  32  arithmetic unit result.
AU_DATA_VALID  in  1  arithmetic unit result valid.
RES_VALID  out  1  result available.
RES_READY  in  1  consumer accepts result.
RES_DATA  out  32  result value.
RES_TAG  out  4  tag of the instruction producing RES_DATA.
RES_ERR  out  1  result aborted by timeout.

Function
REQ-003 SHALL push {op,movi,a,b,tag} into FIFO on any edge with INS_VALID && INS_READY; INS_READY = FIFO not full (combinational from occupancy only).
REQ-004 SHALL implement FSM IDLE, ISSUE, WAIT, OUT; exactly one instruction in flight.
REQ-005 IDLE: if FIFO non-empty -> ISSUE, popping head into operand registers on that edge; else stay.
REQ-006 ISSUE: AU_ACT=1 for exactly this one cycle; -> WAIT unconditionally.
REQ-007 WAIT: AU_ACT=0; operand registers and all AU_* operand outputs held stable; on AU_DATA_VALID=1 capture AU_DATA into RES_DATA, RES_ERR=0 -> OUT.
REQ-008 OUT: RES_VALID=1, RES_DATA/RES_TAG/RES_ERR stable until RES_READY=1; on acceptance -> IDLE.
REQ-009 AU_OP_CODE/AU_MOVI/AU_REG_A SHALL equal registered op/movi/a; INS_B routed to the port selected by movi, other two driven 0; movi 3 drives all three 0.
REQ-010 Latency, ISSUE at cycle N, RES_READY held 1: add/sub/div RES_VALID at N+2; mul RES_VALID at N+5.
REQ-011 AU_DATA_VALID outside WAIT SHALL be ignored.
REQ-012 Simultaneous push and pop in one cycle SHALL both take effect; occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-013 Push while full SHALL NOT occur (INS_READY=0); pop while empty SHALL NOT occur (IDLE stays).

Reset
REQ-014 RST_N=0 SHALL immediately clear, in any state including mid-WAIT: FSM=IDLE, FIFO empty, INS_READY=1, AU_ACT=0, AU_* operands 0, RES_VALID=0, RES_DATA=0, RES_TAG=0, RES_ERR=0, timeout counter 0.
REQ-015 In-flight and queued instructions SHALL be discarded by reset; no result emitted for them.

Configuration
REQ-016 Macro ALU_DISPATCH_TIMEOUT_EN defined: counter runs in WAIT; after TIMEOUT WAIT cycles without AU_DATA_VALID -> OUT with RES_DATA=0, RES_ERR=1, counter cleared on leaving WAIT.
REQ-017 Macro undefined: no counter; WAIT holds indefinitely; RES_ERR tied 0.

Verification
REQ-018 ADD: INS_OP=0, MOVI=0, A=7, B=5, TAG=3, RES_READY=1 -> one AU_ACT pulse, AU_REG_B=5, RES_DATA=12, RES_TAG=3 at ISSUE+2.
REQ-019 MUL: OP=2, MOVI=2, A=6, B=7 -> AU_IMM=7, AU_REG_B=0, operands stable through WAIT, RES_DATA=42 at ISSUE+5.
REQ-020 Backpressure: RES_READY=0, push 6 back-to-back -> 5 accepted (1 in flight + 4 queued), INS_READY=0 at 6th; release RES_READY -> 5 results in push order, tags intact.
REQ-021 Timeout (macro defined, TIMEOUT=15, AU stub never valid) -> RES_VALID with RES_ERR=1, RES_DATA=0 after 15 WAIT cycles; macro undefined -> RES_VALID stays 0.
REQ-022 Reset mid-MUL WAIT with 2 queued -> all outputs at reset values, INS_READY=1, no RES_VALID after release until new push.
REQ-023 DIV: A=9, B=0, MOVI=1 -> AU_MEM=0, RES_DATA=0, RES_ERR=0.
